// File: rtl/exc_pkg.sv
// Shared types and constants for the MEM-stage exception commit logic.
package exc_pkg;

    typedef enum logic [1:0] {RUN, WAIT, COMMIT} state_t;

    // Bit positions within mem_exc_flags_i
    localparam int FLAG_FETCH_ADEL  = 0;
    localparam int FLAG_RI          = 1;
    localparam int FLAG_OV          = 2;
    localparam int FLAG_SYSCALL     = 3;
    localparam int FLAG_BREAK       = 4;
    localparam int FLAG_TRAP        = 5;
    localparam int FLAG_LOAD_ADEL   = 6;
    localparam int FLAG_STORE_ADES  = 7;

    localparam logic [4:0] EXC_INT  = 5'h01;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_TR   = 5'h0d;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

endpackage

// File: rtl/exc_commit_unit_priority.sv
// Combinational priority encoder: picks the single exception to commit for the MEM instruction.
module exc_priority
    import exc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              valid,
    input  logic              int_pending,
    input  logic [7:0]        flags,
    input  logic              eret,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] addr,
    output logic              detect,
    output logic [4:0]        code,
    output logic [ADDR_W-1:0] bad_addr
);

    always_comb begin
        detect   = 1'b0;
        code     = '0;
        bad_addr = '0;
        if (valid) begin
            detect = 1'b1;
            if (int_pending)                  code = EXC_INT;
            else if (flags[FLAG_FETCH_ADEL]) begin
                code     = EXC_ADEL;
                bad_addr = pc;
            end
            else if (flags[FLAG_RI])          code = EXC_RI;
            else if (flags[FLAG_OV])          code = EXC_OV;
            else if (flags[FLAG_TRAP])        code = EXC_TR;
            else if (flags[FLAG_SYSCALL])     code = EXC_SYS;
            else if (flags[FLAG_BREAK])       code = EXC_BP;
            else if (flags[FLAG_LOAD_ADEL]) begin
                code     = EXC_ADEL;
                bad_addr = addr;
            end
            else if (flags[FLAG_STORE_ADES]) begin
                code     = EXC_ADES;
                bad_addr = addr;
            end
            else if (eret)                    code = EXC_ERET;
            else                              detect = 1'b0;
        end
    end

endmodule

// File: rtl/exc_commit_unit.sv
// Selects the MEM-stage exception, waits for the data bus to drain, then issues
// a single-cycle commit pulse with flush and redirect PC for CP0 and the pipeline.
module exc_commit_unit
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_pc_i,
    input  logic              mem_in_delayslot_i,
    input  logic [7:0]        mem_exc_flags_i,
    input  logic              mem_eret_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic              mem_busy_i,
    input  logic [31:0]       cp0_status_i,
    input  logic [31:0]       cp0_cause_i,
    input  logic [31:0]       cp0_epc_i,
    input  logic              wb_cp0_we_i,
    input  logic [4:0]        wb_cp0_waddr_i,
    input  logic [31:0]       wb_cp0_data_i,
    output logic [31:0]       excepttype_o,
    output logic [ADDR_W-1:0] current_inst_addr_o,
    output logic              is_in_delayslot_o,
    output logic [ADDR_W-1:0] bad_addr_o,
    output logic              stall_req_o,
    output logic              flush_o,
    output logic [ADDR_W-1:0] new_pc_o
);

    state_t state;

    logic [31:0]       status_eff, cause_eff, epc_eff;
    logic              int_pending, detect;
    logic [4:0]        live_code;
    logic [ADDR_W-1:0] live_bad, live_new_pc;

    logic [4:0]        lat_code;
    logic [ADDR_W-1:0] lat_pc, lat_bad, lat_new_pc;
    logic              lat_ds;

    logic              fire;
    logic [4:0]        src_code;
    logic [ADDR_W-1:0] src_pc, src_bad, src_new_pc;
    logic              src_ds;

    // An MTC0 retiring in WB this cycle has not reached the CP0 file yet
    always_comb begin
        status_eff = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_STATUS) ? wb_cp0_data_i : cp0_status_i;
        cause_eff  = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_CAUSE)  ? wb_cp0_data_i : cp0_cause_i;
        epc_eff    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_EPC)    ? wb_cp0_data_i : cp0_epc_i;
    end

    assign int_pending = status_eff[0] && !status_eff[1] && |(cause_eff[15:8] & status_eff[15:8]);

    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

    exc_priority #(.ADDR_W(ADDR_W)) u_prio (
        .valid       (mem_valid_i),
        .int_pending (int_pending),
        .flags       (mem_exc_flags_i),
        .eret        (mem_eret_i),
        .pc          (mem_pc_i),
        .addr        (mem_addr_i),
        .detect      (detect),
        .code        (live_code),
        .bad_addr    (live_bad)
    );

    assign live_new_pc = (live_code == EXC_ERET) ? epc_eff[ADDR_W-1:0] : EXC_VECTOR[ADDR_W-1:0];

    // Commit straight from the live inputs when the bus is idle on detection, else from the latch
    assign fire       = !mem_busy_i && ((state == RUN && detect) || state == WAIT);
    assign src_code   = (state == RUN) ? live_code          : lat_code;
    assign src_pc     = (state == RUN) ? mem_pc_i           : lat_pc;
    assign src_ds     = (state == RUN) ? mem_in_delayslot_i : lat_ds;
    assign src_bad    = (state == RUN) ? live_bad           : lat_bad;
    assign src_new_pc = (state == RUN) ? live_new_pc        : lat_new_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= RUN;
            lat_code            <= '0;
            lat_pc              <= '0;
            lat_ds              <= 1'b0;
            lat_bad             <= '0;
            lat_new_pc          <= '0;
            excepttype_o        <= '0;
            current_inst_addr_o <= '0;
            is_in_delayslot_o   <= 1'b0;
            bad_addr_o          <= '0;
            stall_req_o         <= 1'b0;
            flush_o             <= 1'b0;
            new_pc_o            <= '0;
        end else begin
            excepttype_o        <= '0;
            current_inst_addr_o <= '0;
            is_in_delayslot_o   <= 1'b0;
            bad_addr_o          <= '0;
            flush_o             <= 1'b0;
            new_pc_o            <= '0;
            if (fire) begin
                excepttype_o        <= {27'b0, src_code};
                current_inst_addr_o <= src_pc;
                is_in_delayslot_o   <= src_ds;
                bad_addr_o          <= src_bad;
                flush_o             <= 1'b1;
                new_pc_o            <= src_new_pc;
            end
            case (state)
                RUN: if (detect) begin
                    lat_code   <= live_code;
                    lat_pc     <= mem_pc_i;
                    lat_ds     <= mem_in_delayslot_i;
                    lat_bad    <= live_bad;
                    lat_new_pc <= live_new_pc;
                    if (mem_busy_i) begin
                        state       <= WAIT;
                        stall_req_o <= 1'b1;
                    end else begin
                        state <= COMMIT;
                    end
                end
                WAIT: if (!mem_busy_i) begin
                    state       <= COMMIT;
                    stall_req_o <= 1'b0;
                end
                COMMIT:  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule
